if_id_buffer: RTL and testbench

IF_ID_BUFFER -- requirements
Module: if_id_buffer

---
 rtl/if_id_buffer.sv | 97 +++++++++
 tb/tb_if_id_buffer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/if_id_buffer.sv
// if_id_buffer: circular FIFO between the fetch and decode stages.
// The buffer holds up to DEPTH {pc, instr} entries. It uses valid/ready
// handshakes on both sides. Flush discards all buffered entries.
//
// Ports:
//   clk           clock; all state changes on its rising edge
//   reset         asynchronous, active-high reset
//   in_valid      fetch presents an instruction
//   in_pc         PC of the presented instruction
//   in_instr      presented instruction word
//   in_ready      buffer can accept a push (count < DEPTH)
//   flush         discard all entries at the next edge (redirect)
//   out_valid     head entry is valid for decode
//   out_pc        PC of the head entry (0 when empty)
//   out_instr     instruction word of the head entry (0 when empty)
//   out_pc_plus4  out_pc + 4, wrapping modulo 2^32
//   out_ready     decode consumes the head entry
//   count         number of valid entries
module if_id_buffer #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc_plus4,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic             push;
  logic             pop;

  // Handshake qualification. Flush suppresses both sides.
  // in_ready depends only on the registered count, so a pop cannot free a
  // slot for a push in the same cycle.
  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // Head read. When the FIFO is empty, stale storage stays hidden.
  always_comb begin
    out_pc    = 32'h0;
    out_instr = 32'h0;
    if (out_valid) begin
      out_pc    = pc_mem[rd_ptr];
      out_instr = instr_mem[rd_ptr];
    end
  end

  assign out_pc_plus4 = out_pc + 32'd4;

  // Pointer and occupancy state. Pointers wrap naturally, since DEPTH is
  // a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      if (pop)  rd_ptr <= PTR_W'(rd_ptr + 1'b1);
      unique case ({push, pop})
        2'b10:   count <= CNT_W'(count + 1'b1);
        2'b01:   count <= CNT_W'(count - 1'b1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage. It has no reset, because out_valid masks it.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instr;
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed self-checking bench for if_id_buffer.
// Instance u_a has DEPTH=2. Instance u_b has DEPTH=4 and covers pointer wrap.
module tb_if_id_buffer;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  logic        a_in_valid = 1'b0, a_flush = 1'b0, a_out_ready = 1'b0;
  logic [31:0] a_in_pc = '0, a_in_instr = '0;
  logic        a_in_ready, a_out_valid;
  logic [31:0] a_out_pc, a_out_instr, a_out_pc_plus4;
  logic [1:0]  a_count;

  logic        b_in_valid = 1'b0, b_flush = 1'b0, b_out_ready = 1'b0;
  logic [31:0] b_in_pc = '0, b_in_instr = '0;
  logic        b_in_ready, b_out_valid;
  logic [31:0] b_out_pc, b_out_instr, b_out_pc_plus4;
  logic [2:0]  b_count;

  int n_assert = 0;
  int n_fail   = 0;

  if_id_buffer #(.DEPTH(2)) u_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_pc(a_in_pc),
    .in_instr(a_in_instr), .in_ready(a_in_ready), .flush(a_flush),
    .out_valid(a_out_valid), .out_pc(a_out_pc), .out_instr(a_out_instr),
    .out_pc_plus4(a_out_pc_plus4), .out_ready(a_out_ready), .count(a_count)
  );

  if_id_buffer #(.DEPTH(4)) u_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_pc(b_in_pc),
    .in_instr(b_in_instr), .in_ready(b_in_ready), .flush(b_flush),
    .out_valid(b_out_valid), .out_pc(b_out_pc), .out_instr(b_out_instr),
    .out_pc_plus4(b_out_pc_plus4), .out_ready(b_out_ready), .count(b_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] wpc [9];

  initial begin
    // Reset takes effect immediately, before any clock edge.
    #1 reset = 1'b1;
    #1;
    chk("rst_count",  32'(a_count), 32'd0);
    chk("rst_valid",  32'(a_out_valid), 32'd0);
    chk("rst_ready",  32'(a_in_ready), 32'd1);
    chk("rst_pc",     a_out_pc, 32'h0);
    chk("rst_instr",  a_out_instr, 32'h0);
    chk("rst_plus4",  a_out_pc_plus4, 32'h4);
    tick();
    reset = 1'b0;

    // Fill the DEPTH=2 instance while decode stalls.
    a_in_valid = 1'b1; a_in_pc = 32'h0; a_in_instr = 32'h00000013; a_out_ready = 1'b0;
    #1 chk("no_bypass", 32'(a_out_valid), 32'd0);
    tick();
    chk("fill1_count", 32'(a_count), 32'd1);
    chk("fill1_pc",    a_out_pc, 32'h0);
    a_in_pc = 32'h4; a_in_instr = 32'h00500093;
    tick();
    chk("fill2_count", 32'(a_count), 32'd2);
    chk("fill2_ready", 32'(a_in_ready), 32'd0);
    chk("fill2_pc",    a_out_pc, 32'h0);
    chk("fill2_instr", a_out_instr, 32'h00000013);
    a_in_pc = 32'h8; a_in_instr = 32'hDEADBEEF;
    tick();
    chk("fill3_count", 32'(a_count), 32'd2);
    chk("fill3_pc",    a_out_pc, 32'h0);

    // Drain while full. The pop must not let the pending push in.
    a_out_ready = 1'b1;
    tick();
    chk("drain1_pc",    a_out_pc, 32'h4);
    chk("drain1_instr", a_out_instr, 32'h00500093);
    chk("drain1_count", 32'(a_count), 32'd1);
    a_in_valid = 1'b0;
    tick();
    chk("drain2_valid", 32'(a_out_valid), 32'd0);
    chk("drain2_count", 32'(a_count), 32'd0);
    chk("drain2_plus4", a_out_pc_plus4, 32'h4);
    chk("drain2_pc",    a_out_pc, 32'h0);

    // Pop while empty has no effect.
    tick();
    chk("empty_pop_count", 32'(a_count), 32'd0);

    // Push while empty, with out_ready high. Only the push happens.
    a_in_valid = 1'b1; a_in_pc = 32'h8; a_in_instr = 32'h11111111;
    tick();
    chk("prime_count", 32'(a_count), 32'd1);
    chk("prime_pc",    a_out_pc, 32'h8);

    // Streaming at count=1. The head follows the push one cycle later.
    for (int i = 0; i < 10; i++) begin
      a_in_pc    = 32'hC + 32'(4 * i);
      a_in_instr = a_in_pc ^ 32'hA5A50000;
      tick();
      chk("stream_count", 32'(a_count), 32'd1);
      chk("stream_pc",    a_out_pc, 32'hC + 32'(4 * i));
      chk("stream_instr", a_out_instr, (32'hC + 32'(4 * i)) ^ 32'hA5A50000);
    end

    // Flush overrides a same-cycle push and pop.
    a_flush = 1'b1; a_in_pc = 32'h200; a_in_instr = 32'h22222222;
    tick();
    chk("flush_count", 32'(a_count), 32'd0);
    chk("flush_valid", 32'(a_out_valid), 32'd0);
    a_flush = 1'b0; a_in_valid = 1'b0;
    tick();
    chk("flush_absent", 32'(a_count), 32'd0);

    // Async reset between edges while two entries are buffered.
    a_out_ready = 1'b0; a_in_valid = 1'b1;
    a_in_pc = 32'h40; a_in_instr = 32'h33333333;
    tick();
    a_in_pc = 32'h44;
    tick();
    chk("pre_rst_count", 32'(a_count), 32'd2);
    a_in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_valid", 32'(a_out_valid), 32'd0);
    chk("async_ready", 32'(a_in_ready), 32'd1);
    chk("async_count", 32'(a_count), 32'd0);
    #1 reset = 1'b0;
    a_in_valid = 1'b1; a_in_pc = 32'h100; a_in_instr = 32'h00A00113;
    tick();
    chk("post_rst_pc",    a_out_pc, 32'h100);
    chk("post_rst_instr", a_out_instr, 32'h00A00113);
    a_in_valid = 1'b0;

    // Pointer wrap on the DEPTH=4 instance. Reset cleared it above.
    for (int k = 0; k < 8; k++) wpc[k] = 32'h1000 + 32'(4 * k);
    wpc[8] = 32'hFFFFFFFC;
    chk("b_rst_count", 32'(b_count), 32'd0);
    b_in_valid = 1'b1; b_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      b_in_pc = wpc[k]; b_in_instr = ~wpc[k];
      tick();
    end
    chk("wrap_fill_count", 32'(b_count), 32'd3);
    chk("wrap_fill_pc",    b_out_pc, wpc[0]);
    b_out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      b_in_pc = wpc[3 + j]; b_in_instr = ~wpc[3 + j];
      tick();
      chk("wrap_stream_pc",    b_out_pc, wpc[j + 1]);
      chk("wrap_stream_count", 32'(b_count), 32'd3);
    end
    b_in_valid = 1'b0;
    tick();
    chk("wrap_pop1_pc", b_out_pc, wpc[7]);
    tick();
    chk("wrap_head_pc",    b_out_pc, 32'hFFFFFFFC);
    chk("wrap_head_instr", b_out_instr, 32'h00000003);
    chk("wrap_plus4",      b_out_pc_plus4, 32'h00000000);
    tick();
    chk("wrap_empty_valid", 32'(b_out_valid), 32'd0);
    chk("wrap_empty_plus4", b_out_pc_plus4, 32'h4);
    b_out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
